// File: rtl/fifo_mq_pkg.sv
// Shared constants, width helper, saturating add and per-queue status type
// for the multi-queue FWFT FIFO.
package fifo_mq_pkg;

  localparam int unsigned STATS_WIDTH      = 32'd16;
  localparam int unsigned STATUS_CNT_WIDTH = 32'd16;

  typedef struct packed {
    logic [STATUS_CNT_WIDTH-1:0] count;
    logic                        nonempty;
    logic                        almost_full;
  } q_status_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  function automatic logic [STATS_WIDTH-1:0] sat_add(
    input logic [STATS_WIDTH-1:0] a,
    input logic [STATS_WIDTH-1:0] b
  );
    logic [STATS_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STATS_WIDTH] ? {STATS_WIDTH{1'b1}} : sum[STATS_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fifo_mq_ptr.sv
// Per-queue read/write pointers and occupancy count; clear wins over push/pop.
module fifo_mq_ptr
  import fifo_mq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = clog2_min1(DEPTH),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic                 pop_any,
  input  logic                 clear,
  output logic [PTR_WIDTH-1:0] o__rd_ptr,
  output logic [PTR_WIDTH-1:0] o__wr_ptr,
  output logic [CNT_WIDTH-1:0] o__count,
  output logic                 o__full,
  output logic                 o__empty
);

  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? {PTR_WIDTH{1'b0}} : p + PTR_WIDTH'(1);
  endfunction

  // Next pointer/count state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = {PTR_WIDTH{1'b0}};
      wr_ptr_d = {PTR_WIDTH{1'b0}};
      count_d  = {CNT_WIDTH{1'b0}};
    end else begin
      wr_ptr_d = push    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_any ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push, pop_any})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= {PTR_WIDTH{1'b0}};
      wr_ptr_q <= {PTR_WIDTH{1'b0}};
      count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o__rd_ptr = rd_ptr_q;
  assign o__wr_ptr = wr_ptr_q;
  assign o__count  = count_q;
  assign o__full   = (count_q == CNT_WIDTH'(DEPTH));
  assign o__empty  = (count_q == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/fifo_mq.sv
// Multi-queue FWFT FIFO over one statically partitioned buffer.
// Optional per-queue drop statistics with `define FIFO_MQ_STATS_EN.
module fifo_mq
  import fifo_mq_pkg::*;
#(
  parameter int   DATA_WIDTH         = 64,
  parameter int   DEPTH              = 4,
  parameter int   NUM_QUEUES         = 4,
  parameter int   ALMOST_FULL_THRESH = DEPTH - 1,
  localparam int  QID_WIDTH          = clog2_min1(NUM_QUEUES),
  localparam int  PTR_WIDTH          = clog2_min1(DEPTH),
  localparam int  CNT_WIDTH          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i__enq_valid,
  input  logic [QID_WIDTH-1:0]  i__enq_qid,
  input  logic [DATA_WIDTH-1:0] i__enq_data,
  output logic                  o__enq_ready,
  input  logic [QID_WIDTH-1:0]  i__deq_qid,
  output logic                  o__deq_valid,
  output logic [DATA_WIDTH-1:0] o__deq_data,
  input  logic                  i__deq_ready,
  input  logic                  i__drop_valid,
  input  logic [QID_WIDTH-1:0]  i__drop_qid,
  output logic                  o__drop_ack,
  input  logic                  i__clear_valid,
  input  logic [QID_WIDTH-1:0]  i__clear_qid,
`ifdef FIFO_MQ_STATS_EN
  output logic [STATS_WIDTH-1:0] oa__drop_count [NUM_QUEUES],
`endif
  output logic [CNT_WIDTH-1:0]  oa__queue_length [NUM_QUEUES],
  output logic [NUM_QUEUES-1:0] o__nonempty_mask,
  output logic [NUM_QUEUES-1:0] o__almost_full_mask
);

  localparam int ENTRIES    = NUM_QUEUES * DEPTH;
  localparam int ADDR_WIDTH = clog2_min1(ENTRIES);

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic [PTR_WIDTH-1:0]  rd_ptr_s [NUM_QUEUES];
  logic [PTR_WIDTH-1:0]  wr_ptr_s [NUM_QUEUES];
  logic [CNT_WIDTH-1:0]  count_s  [NUM_QUEUES];
  q_status_t             status_s [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] full_s, empty_s;
  logic [NUM_QUEUES-1:0] enq_hit_s, deq_hit_s, drop_hit_s, clr_hit_s;
  logic [NUM_QUEUES-1:0] push_s, pop_any_s;
  logic                  enq_ready_s, deq_valid_s, pop_s, drop_ack_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
  logic                  unused_status_s;

  // Qid decode; an out-of-range qid matches no queue, so it is naturally inert
  always_comb begin
    enq_hit_s  = {NUM_QUEUES{1'b0}};
    deq_hit_s  = {NUM_QUEUES{1'b0}};
    drop_hit_s = {NUM_QUEUES{1'b0}};
    clr_hit_s  = {NUM_QUEUES{1'b0}};
    for (int q = 0; q < NUM_QUEUES; q++) begin
      enq_hit_s[q]  = (i__enq_qid  == QID_WIDTH'(q));
      deq_hit_s[q]  = (i__deq_qid  == QID_WIDTH'(q));
      drop_hit_s[q] = (i__drop_qid == QID_WIDTH'(q));
      clr_hit_s[q]  = i__clear_valid & (i__clear_qid == QID_WIDTH'(q));
    end
  end

  // Handshakes and arbitration: one head removal per cycle, pop before drop
  always_comb begin
    enq_ready_s = reset_n & (|enq_hit_s) & ~(|(enq_hit_s & full_s))
                & ~(|(enq_hit_s & clr_hit_s));
    deq_valid_s = |(deq_hit_s & ~empty_s);
    pop_s       = deq_valid_s & i__deq_ready;
    drop_ack_s  = i__drop_valid & (|(drop_hit_s & ~empty_s)) & ~pop_s
                & ~(|(drop_hit_s & clr_hit_s));
    push_s      = enq_hit_s & {NUM_QUEUES{i__enq_valid & enq_ready_s}};
    pop_any_s   = (deq_hit_s & {NUM_QUEUES{pop_s}})
                | (drop_hit_s & {NUM_QUEUES{drop_ack_s}});
  end

  // Buffer addresses: queue q owns the slice q*DEPTH .. q*DEPTH+DEPTH-1
  always_comb begin
    wr_addr_s = {ADDR_WIDTH{1'b0}};
    rd_addr_s = {ADDR_WIDTH{1'b0}};
    for (int q = 0; q < NUM_QUEUES; q++) begin
      wr_addr_s = wr_addr_s | ({ADDR_WIDTH{enq_hit_s[q]}}
                & (ADDR_WIDTH'(q * DEPTH) + ADDR_WIDTH'(wr_ptr_s[q])));
      rd_addr_s = rd_addr_s | ({ADDR_WIDTH{deq_hit_s[q]}}
                & (ADDR_WIDTH'(q * DEPTH) + ADDR_WIDTH'(rd_ptr_s[q])));
    end
  end

  // Storage write port; contents deliberately carry no reset
  always_ff @(posedge clk) begin
    if (|push_s) begin
      mem_q[wr_addr_s] <= i__enq_data;
    end
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    fifo_mq_ptr #(
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ptr (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_s[q]),
      .pop_any   (pop_any_s[q]),
      .clear     (clr_hit_s[q]),
      .o__rd_ptr (rd_ptr_s[q]),
      .o__wr_ptr (wr_ptr_s[q]),
      .o__count  (count_s[q]),
      .o__full   (full_s[q]),
      .o__empty  (empty_s[q])
    );
  end

  // Per-queue status derived from registered counts
  always_comb begin
    unused_status_s = 1'b0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      status_s[q].count       = STATUS_CNT_WIDTH'(count_s[q]);
      status_s[q].nonempty    = ~empty_s[q];
      status_s[q].almost_full = (32'(count_s[q]) >= ALMOST_FULL_THRESH);
      unused_status_s         = unused_status_s ^ (^status_s[q].count);
    end
  end

  // Status fan-out to ports
  always_comb begin
    o__nonempty_mask    = {NUM_QUEUES{1'b0}};
    o__almost_full_mask = {NUM_QUEUES{1'b0}};
    for (int q = 0; q < NUM_QUEUES; q++) begin
      oa__queue_length[q]    = status_s[q].count[CNT_WIDTH-1:0];
      o__nonempty_mask[q]    = status_s[q].nonempty;
      o__almost_full_mask[q] = status_s[q].almost_full;
    end
  end

  assign o__enq_ready = enq_ready_s;
  assign o__deq_valid = deq_valid_s;
  assign o__deq_data  = mem_q[rd_addr_s];
  assign o__drop_ack  = drop_ack_s;

`ifdef FIFO_MQ_STATS_EN
  logic [STATS_WIDTH-1:0] drop_cnt_q [NUM_QUEUES];
  logic [STATS_WIDTH-1:0] drop_cnt_d [NUM_QUEUES];

  // A clear discards the whole current occupancy; a drop can never hit a clearing queue
  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (clr_hit_s[q]) begin
        drop_cnt_d[q] = sat_add(drop_cnt_q[q], status_s[q].count);
      end else if (drop_hit_s[q] & drop_ack_s) begin
        drop_cnt_d[q] = sat_add(drop_cnt_q[q], STATS_WIDTH'(1));
      end else begin
        drop_cnt_d[q] = drop_cnt_q[q];
      end
    end
  end

  // Drop statistics registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        drop_cnt_q[q] <= {STATS_WIDTH{1'b0}};
      end
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign oa__drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_mq.sv
// Directed bench for fifo_mq: queue-based reference model checked every cycle
// plus hand-computed literal checks at key points of each scenario.
module tb_fifo_mq;

  localparam int NQ    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enq_valid, deq_ready, drop_valid, clear_valid;
  logic [1:0]    enq_qid, deq_qid, drop_qid, clear_qid;
  logic [DW-1:0] enq_data;
  logic          enq_ready, deq_valid, drop_ack;
  logic [DW-1:0] deq_data;
  logic [2:0]    len [NQ];
  logic [NQ-1:0] ne_mask, af_mask;
`ifdef FIFO_MQ_STATS_EN
  logic [15:0]   drop_count [NQ];
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] mq [NQ][$];
  int            stats [NQ];

  always #5 clk = ~clk;

  fifo_mq dut (
    .clk                 (clk),
    .reset_n             (rst_n),
    .i__enq_valid        (enq_valid),
    .i__enq_qid          (enq_qid),
    .i__enq_data         (enq_data),
    .o__enq_ready        (enq_ready),
    .i__deq_qid          (deq_qid),
    .o__deq_valid        (deq_valid),
    .o__deq_data         (deq_data),
    .i__deq_ready        (deq_ready),
    .i__drop_valid       (drop_valid),
    .i__drop_qid         (drop_qid),
    .o__drop_ack         (drop_ack),
    .i__clear_valid      (clear_valid),
    .i__clear_qid        (clear_qid),
`ifdef FIFO_MQ_STATS_EN
    .oa__drop_count      (drop_count),
`endif
    .oa__queue_length    (len),
    .o__nonempty_mask    (ne_mask),
    .o__almost_full_mask (af_mask)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues, decisions taken from the documented rules
  function automatic bit m_ready();
    return rst_n && (mq[enq_qid].size() < DEPTH) && !(clear_valid && clear_qid == enq_qid);
  endfunction
  function automatic bit m_dvalid();
    return mq[deq_qid].size() != 0;
  endfunction
  function automatic bit m_pop();
    return m_dvalid() && deq_ready;
  endfunction
  function automatic bit m_ack();
    return drop_valid && (mq[drop_qid].size() != 0) && !m_pop()
           && !(clear_valid && clear_qid == drop_qid);
  endfunction
  function automatic int sat16(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  initial for (int q = 0; q < NQ; q++) stats[q] = 0;

  always @(negedge rst_n) begin
    for (int q = 0; q < NQ; q++) begin
      mq[q].delete();
      stats[q] = 0;
    end
  end

  always @(posedge clk) begin
    bit r, p, a;
    if (rst_n) begin
      r = m_ready();
      p = m_pop();
      a = m_ack();
      if (clear_valid) stats[clear_qid] = sat16(stats[clear_qid], mq[clear_qid].size());
      if (p) void'(mq[deq_qid].pop_front());
      if (a) begin
        void'(mq[drop_qid].pop_front());
        stats[drop_qid] = sat16(stats[drop_qid], 1);
      end
      if (clear_valid) mq[clear_qid].delete();
      if (enq_valid && r) mq[enq_qid].push_back(enq_data);
    end
  end

  always @(negedge clk) begin
    logic [NQ-1:0] ne, af;
    chk("enq_ready", 64'(enq_ready), 64'(m_ready()));
    chk("deq_valid", 64'(deq_valid), 64'(m_dvalid()));
    if (m_dvalid()) chk("deq_data", deq_data, mq[deq_qid][0]);
    chk("drop_ack", 64'(drop_ack), 64'(m_ack()));
    for (int q = 0; q < NQ; q++) begin
      chk("queue_length", 64'(len[q]), 64'(mq[q].size()));
      ne[q] = mq[q].size() != 0;
      af[q] = mq[q].size() >= DEPTH - 1;
`ifdef FIFO_MQ_STATS_EN
      chk("drop_count", 64'(drop_count[q]), 64'(stats[q]));
`endif
    end
    chk("nonempty_mask", 64'(ne_mask), 64'(ne));
    chk("almost_full_mask", 64'(af_mask), 64'(af));
  end

  task automatic idle();
    enq_valid = 1'b0; deq_ready = 1'b0; drop_valid = 1'b0; clear_valid = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic push(input int q, input logic [DW-1:0] d);
    idle(); enq_valid = 1'b1; enq_qid = 2'(q); enq_data = d; tick(); idle();
  endtask

  initial begin
    idle();
    enq_qid = 2'd0; deq_qid = 2'd0; drop_qid = 2'd0; clear_qid = 2'd0; enq_data = 64'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_ready", 64'(enq_ready), 64'h0);
    chk("lit_rst_len0", 64'(len[0]), 64'h0);
    chk("lit_rst_mask", 64'(ne_mask), 64'h0);
    rst_n = 1'b1;
    tick();

    // basic FWFT order across two queues
    push(0, 64'hA1); push(0, 64'hA2); push(2, 64'hB1);
    chk("lit_len0_2", 64'(len[0]), 64'h2);
    chk("lit_len2_1", 64'(len[2]), 64'h1);
    deq_qid = 2'd0; #1;
    chk("lit_head_A1", deq_data, 64'hA1);
    deq_ready = 1'b1; tick();
    chk("lit_head_A2", deq_data, 64'hA2);
    tick(); idle();
    chk("lit_ne_0100", 64'(ne_mask), 64'h4);
    chk("lit_len2_still1", 64'(len[2]), 64'h1);

    // fill q1, almost-full, full rejection, pop then pop+push
    push(1, 64'h10); push(1, 64'h11); push(1, 64'h12);
    chk("lit_len1_3", 64'(len[1]), 64'h3);
    chk("lit_af_0010", 64'(af_mask), 64'h2);
    push(1, 64'h13);
    chk("lit_len1_4", 64'(len[1]), 64'h4);
    enq_valid = 1'b1; enq_qid = 2'd1; enq_data = 64'hFF; #1;
    chk("lit_full_ready", 64'(enq_ready), 64'h0);
    tick();
    enq_valid = 1'b0; enq_qid = 2'd0; #1;
    chk("lit_q0_ready", 64'(enq_ready), 64'h1);
    chk("lit_len1_held", 64'(len[1]), 64'h4);
    deq_qid = 2'd1; deq_ready = 1'b1; tick();
    enq_valid = 1'b1; enq_qid = 2'd1; enq_data = 64'h14; tick(); idle();
    chk("lit_len1_3b", 64'(len[1]), 64'h3);
    chk("lit_head_12", deq_data, 64'h12);
    deq_ready = 1'b1; repeat (3) tick(); idle();

    // steady push+pop on q3 across pointer wrap
    push(3, 64'h31); push(3, 64'h32);
    deq_qid = 2'd3;
    for (int i = 0; i < 10; i++) begin
      enq_valid = 1'b1; enq_qid = 2'd3; enq_data = 64'hC3 + 64'(i); deq_ready = 1'b1;
      tick();
      chk("lit_len3_2", 64'(len[3]), 64'h2);
    end
    idle();
    chk("lit_head_CB", deq_data, 64'hCB);
    chk("lit_model_q3", 64'(mq[3].size()), 64'h2);
    deq_ready = 1'b1; repeat (2) tick(); idle();

    // head-drop
    push(0, 64'h11); push(0, 64'h22);
    drop_valid = 1'b1; drop_qid = 2'd0; #1;
    chk("lit_drop_ack1", 64'(drop_ack), 64'h1);
    tick(); idle(); deq_qid = 2'd0; #1;
    chk("lit_head_22", deq_data, 64'h22);
    deq_ready = 1'b1; drop_valid = 1'b1; drop_qid = 2'd0; #1;
    chk("lit_drop_vs_pop", 64'(drop_ack), 64'h0);
    tick(); idle();
    push(0, 64'h33);
    deq_ready = 1'b1; drop_valid = 1'b1; drop_qid = 2'd2; #1;
    chk("lit_drop_other_q", 64'(drop_ack), 64'h0);
    tick(); idle();
    drop_valid = 1'b1; drop_qid = 2'd0; #1;
    chk("lit_drop_empty", 64'(drop_ack), 64'h0);
    tick();
    drop_qid = 2'd2; #1;
    chk("lit_drop_q2", 64'(drop_ack), 64'h1);
    tick(); idle();

    // clear with concurrent push
    push(2, 64'h51); push(2, 64'h52); push(2, 64'h53);
    clear_valid = 1'b1; clear_qid = 2'd2;
    enq_valid = 1'b1; enq_qid = 2'd2; enq_data = 64'h54; #1;
    chk("lit_clear_ready", 64'(enq_ready), 64'h0);
    tick(); idle();
    chk("lit_len2_clr", 64'(len[2]), 64'h0);
`ifdef FIFO_MQ_STATS_EN
    chk("lit_stats_q2", 64'(drop_count[2]), 64'h4);
    chk("lit_stats_q0", 64'(drop_count[0]), 64'h1);
`endif

    // asynchronous reset mid-burst
    enq_valid = 1'b1; enq_qid = 2'd0; enq_data = 64'h60; tick();
    enq_data = 64'h61; tick();
    #2 rst_n = 1'b0; #1;
    for (int q = 0; q < NQ; q++) chk("lit_arst_len", 64'(len[q]), 64'h0);
    chk("lit_arst_ne", 64'(ne_mask), 64'h0);
    chk("lit_arst_af", 64'(af_mask), 64'h0);
    chk("lit_arst_ready", 64'(enq_ready), 64'h0);
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    enq_valid = 1'b1; enq_qid = 2'd0; enq_data = 64'h77; deq_qid = 2'd0; #1;
    chk("lit_no_bypass", 64'(deq_valid), 64'h0);
    tick(); idle();
    chk("lit_post_rst_valid", 64'(deq_valid), 64'h1);
    chk("lit_post_rst_data", deq_data, 64'h77);
`ifdef FIFO_MQ_STATS_EN
    chk("lit_stats_rst", 64'(drop_count[2]), 64'h0);
`endif
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
